alu_issue_stage: RTL and testbench

Registered issue/retire wrapper around the 32-bit combinational `alu`. It accepts operations from the decode side over a valid/ready handshake and holds them in an operand register that drives the ALU. It captures the ALU's result and flags into a 2-entry retire FIFO, and presents them to writeback over a second valid/ready handshake. It also keeps a sticky overflow flag and a retired-operation counter.

---
 rtl/alu_issue_stage.sv | 122 ++++++++++++
 tb/tb_alu_issue_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/retire wrapper around a combinational 32-bit ALU: one registered EX stage feeding the ALU,
// a 2-entry retire FIFO toward writeback, a sticky overflow flag and a retired-op counter.
module alu_issue_stage #(
   parameter int unsigned TAGW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic [2:0]      in_cmd,
   input  logic [TAGW-1:0] in_tag,
   output logic [31:0]     alu_a,
   output logic [31:0]     alu_b,
   output logic [2:0]      alu_cmd,
   input  logic [31:0]     alu_result,
   input  logic            alu_carryout,
   input  logic            alu_zero,
   input  logic            alu_overflow,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_result,
   output logic            out_carryout,
   output logic            out_zero,
   output logic            out_overflow,
   output logic [TAGW-1:0] out_tag,
   output logic            sticky_ovf,
   input  logic            sticky_clr,
   output logic [15:0]     retired
);

   localparam int unsigned EntW = TAGW + 35;

   logic            r_ex_valid;
   logic [31:0]     r_ex_a;
   logic [31:0]     r_ex_b;
   logic [2:0]      r_ex_cmd;
   logic [TAGW-1:0] r_ex_tag;
   logic [EntW-1:0] r_mem [2];
   logic            r_head;
   logic            r_tail;
   logic [1:0]      r_cnt;
   logic            r_sticky;
   logic [15:0]     r_retired;

   logic            w_acc;
   logic            w_pop;
   logic            w_push;
   logic [EntW-1:0] w_head;

   assign out_valid = (r_cnt != 2'd0);
   assign w_pop     = out_valid & out_ready;
   // A full FIFO still takes the EX op when the head leaves in the same cycle.
   assign w_push    = r_ex_valid & ((r_cnt < 2'd2) | w_pop);
   assign in_ready  = ~r_ex_valid | w_push;
   assign w_acc     = in_valid & in_ready;

   assign alu_a   = r_ex_a;
   assign alu_b   = r_ex_b;
   assign alu_cmd = r_ex_cmd;

   assign w_head = r_mem[r_head];
   assign {out_result, out_carryout, out_zero, out_overflow, out_tag} = w_head;

   assign sticky_ovf = r_sticky;
   assign retired    = r_retired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_cmd   <= '0;
         r_ex_tag   <= '0;
      end else if (w_acc) begin
         r_ex_valid <= 1'b1;
         r_ex_a     <= in_a;
         r_ex_b     <= in_b;
         r_ex_cmd   <= in_cmd;
         r_ex_tag   <= in_tag;
      end else if (w_push) begin
         r_ex_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_head   <= 1'b0;
         r_tail   <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= {alu_result, alu_carryout, alu_zero, alu_overflow, r_ex_tag};
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         if (w_push & ~w_pop) begin
            r_cnt <= r_cnt + 2'd1;
         end else if (w_pop & ~w_push) begin
            r_cnt <= r_cnt - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky  <= 1'b0;
         r_retired <= 16'd0;
      end else begin
         r_sticky <= (r_sticky & ~sticky_clr) | (w_push & alu_overflow);
         if (w_pop) begin
            r_retired <= r_retired + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* ports, queue scoreboard fed at accept
// time and drained by an output monitor, directed plus randomized traffic.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        z;
      logic        o;
      logic [3:0]  tag;
   } ent_t;

   localparam longint MaxS = 64'sd2147483647;
   localparam longint MinS = -64'sd2147483648;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [2:0]  in_cmd;
   logic [3:0]  in_tag;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_cmd;
   logic [31:0] alu_result;
   logic        alu_carryout;
   logic        alu_zero;
   logic        alu_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_carryout;
   logic        out_zero;
   logic        out_overflow;
   logic [3:0]  out_tag;
   logic        sticky_ovf;
   logic        sticky_clr;
   logic [15:0] retired;

   ent_t        q[$];
   int          checks;
   int          errors;
   int          stall_cnt;
   logic [15:0] exp_ret;
   logic        rand_rdy;

   alu_issue_stage #(.TAGW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_cmd       (in_cmd),
      .in_tag       (in_tag),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_cmd      (alu_cmd),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carryout (out_carryout),
      .out_zero     (out_zero),
      .out_overflow (out_overflow),
      .out_tag      (out_tag),
      .sticky_ovf   (sticky_ovf),
      .sticky_clr   (sticky_clr),
      .retired      (retired)
   );

   // Stand-in for the combinational alu: shared adder with B inversion for subtract.
   logic [31:0] w_bb;
   logic [32:0] w_sum;
   always_comb begin
      w_bb         = (alu_cmd == 3'd1) ? ~alu_b : alu_b;
      w_sum        = {1'b0, alu_a} + {1'b0, w_bb} + 33'(alu_cmd == 3'd1);
      alu_result   = 32'd0;
      alu_carryout = 1'b0;
      alu_zero     = 1'b0;
      alu_overflow = 1'b0;
      case (alu_cmd)
         3'd0, 3'd1: begin
            alu_result   = w_sum[31:0];
            alu_carryout = w_sum[32];
            alu_zero     = (w_sum[31:0] == 32'd0);
            alu_overflow = (alu_a[31] == w_bb[31]) && (w_sum[31] != alu_a[31]);
         end
         3'd2: alu_result = alu_a ^ alu_b;
         3'd3: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         3'd4: alu_result = alu_a & alu_b;
         3'd5: alu_result = ~(alu_a & alu_b);
         3'd6: alu_result = ~(alu_a | alu_b);
         default: alu_result = alu_a | alu_b;
      endcase
   end

   // Reference: plain integer arithmetic on the mathematical values.
   function automatic ent_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] cmd, input logic [3:0] tag);
      ent_t   e;
      longint sa;
      longint sb;
      longint s;
      longint unsigned ua;
      longint unsigned ub;
      e     = '0;
      e.tag = tag;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      ua    = {32'd0, a};
      ub    = {32'd0, b};
      case (cmd)
         3'd0: begin
            s     = sa + sb;
            e.res = a + b;
            e.c   = (ua + ub) > 64'hFFFF_FFFF;
            e.o   = (s > MaxS) || (s < MinS);
            e.z   = (e.res == 32'd0);
         end
         3'd1: begin
            s     = sa - sb;
            e.res = a - b;
            e.c   = (ua >= ub);
            e.o   = (s > MaxS) || (s < MinS);
            e.z   = (e.res == 32'd0);
         end
         3'd2: e.res = a ^ b;
         3'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: e.res = a & b;
         3'd5: e.res = ~(a & b);
         3'd6: e.res = ~(a | b);
         default: e.res = a | b;
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Output monitor: head must always equal the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("retired", retired, exp_ret);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("out_valid_unexpected", out_valid, 0);
            end else begin
               chk("head_entry", {out_result, out_carryout, out_zero, out_overflow, out_tag}, q[0]);
               if (out_ready) begin
                  void'(q.pop_front());
                  exp_ret = exp_ret + 16'd1;
               end
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                        input logic [3:0] tag);
      int waits = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cmd   = cmd;
      in_tag   = tag;
      @(negedge clk);
      while (!in_ready) begin
         waits++;
         stall_cnt++;
         if (waits > 200) begin
            chk("issue_timeout", waits, 0);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      q.push_back(ref_op(a, b, cmd, tag));
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic issue_rand();
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(a, b, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue_empty", q.size(), 0);
      chk("drain_out_valid", out_valid, 0);
   endtask

   task automatic chk_reset_state();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_fields", {out_result, out_carryout, out_zero, out_overflow, out_tag}, 0);
      chk("rst_alu_ops", {alu_a, alu_b, alu_cmd}, 0);
      chk("rst_sticky", sticky_ovf, 0);
      chk("rst_retired", retired, 0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      stall_cnt  = 0;
      exp_ret    = 16'd0;
      rand_rdy   = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      in_cmd     = '0;
      in_tag     = '0;
      out_ready  = 1'b0;
      sticky_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single add, held at the output until popped.
      issue(32'd7, 32'd5, 3'd0, 4'd3);
      in_valid = 1'b0;
      chk("single_not_yet_visible", out_valid, 0);
      @(posedge clk);
      #1;
      chk("single_visible", out_valid, 1);
      chk("single_result", {out_result, out_carryout, out_overflow, out_tag}, {32'd12, 1'b0, 1'b0, 4'd3});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("single_retired", retired, 1);

      // Overflow sets sticky; set beats a simultaneous clear; clear alone drops it.
      issue(32'h7FFF_FFFF, 32'd1, 3'd0, 4'd5);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("sticky_set", sticky_ovf, 1);
      issue(32'h8000_0000, 32'h8000_0000, 3'd0, 4'd6);
      in_valid   = 1'b0;
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      chk("sticky_set_wins", sticky_ovf, 1);
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      chk("sticky_clear", sticky_ovf, 0);
      drain();

      // Backpressure: three absorbed, fourth waits until out_ready rises.
      out_ready = 1'b0;
      for (int t = 0; t < 3; t++) issue(32'(t), 32'(t * 3), 3'd0, 4'(t));
      in_valid = 1'b1;
      in_a     = 32'd3;
      in_b     = 32'd9;
      in_cmd   = 3'd0;
      in_tag   = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_same_cycle", in_ready, 1);
      @(negedge clk);
      if (in_ready) q.push_back(ref_op(32'd3, 32'd9, 3'd0, 4'd3));
      @(posedge clk);
      #1;
      drain();

      // Full throughput: no stalls, 100 retires.
      begin
         logic [15:0] base;
         base      = exp_ret;
         stall_cnt = 0;
         for (int i = 0; i < 100; i++) issue_rand();
         drain();
         chk("tput_stalls", stall_cnt, 0);
         chk("tput_retired", retired, 16'(base + 16'd100));
      end

      // FIFO kept near full with random downstream readiness.
      rand_rdy  = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 200; i++) issue_rand();
      rand_rdy = 1'b0;
      drain();

      // Reset with operations in flight.
      out_ready = 1'b0;
      sticky_clr = 1'b0;
      issue(32'h7FFF_FFFF, 32'd2, 3'd0, 4'd1);
      issue(32'd10, 32'd4, 3'd1, 4'd2);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      q.delete();
      exp_ret  = 16'd0;
      #1;
      chk_reset_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_out_valid", out_valid, 0);

      // Retired counter wraps after exactly 65536 pops.
      out_ready = 1'b1;
      for (int i = 0; i < 65536; i++) issue_rand();
      drain();
      chk("retired_wrap", retired, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
